ext_io_responder: RTL and testbench

EXT_IO_RESPONDER -- requirements
Module: ext_io_responder

---
 rtl/cpu_params_pkg.sv | 23 ++
 rtl/cpu_structs_pkg.sv | 20 ++
 rtl/io_tx_fifo.sv | 58 +++++
 rtl/ext_io_responder.sv | 180 ++++++++++++++++++
 tb/tb_ext_io_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_params_pkg.sv
// Shared widths, the external I/O window base and the responder register map.
// Offsets are relative to the responder's BASE_ADDR.
package cpu_params_pkg;

    localparam int PC_SZ = 32;
    localparam int RSZ   = 32;

    localparam logic [PC_SZ-1:0] Ext_IO_Addr_Lo = 32'h0000_F000;

    localparam logic [PC_SZ-1:0] OFF_SCRATCH0  = 32'h0000_0000;
    localparam logic [PC_SZ-1:0] OFF_SCRATCH1  = 32'h0000_0004;
    localparam logic [PC_SZ-1:0] OFF_GPIO_OUT  = 32'h0000_0008;
    localparam logic [PC_SZ-1:0] OFF_GPIO_IN   = 32'h0000_000C;
    localparam logic [PC_SZ-1:0] OFF_TX_DATA   = 32'h0000_0010;
    localparam logic [PC_SZ-1:0] OFF_TX_STAT   = 32'h0000_0014;
    localparam logic [PC_SZ-1:0] OFF_CYCLE_CNT = 32'h0000_0018;

    localparam int TX_STAT_EMPTY_BIT = 0;
    localparam int TX_STAT_FULL_BIT  = 1;
    localparam int TX_STAT_COUNT_LSB = 2;
    localparam int TX_STAT_COUNT_MSB = 5;

endpackage

// File: rtl/cpu_structs_pkg.sv
// Types shared by the external I/O responder: FSM states and a captured access.
package cpu_structs_pkg;

    import cpu_params_pkg::*;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        RECOVER
    } io_state_t;

    typedef struct packed {
        logic             rd;
        logic             wr;
        logic [PC_SZ-1:0] addr;
        logic [RSZ-1:0]   data;
    } io_access_t;

endpackage

// File: rtl/io_tx_fifo.sv
// Small synchronous FIFO feeding the TX valid/ready drain port.
// A push is accepted while full as long as a pop happens on the same edge.
module io_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ext_io_responder.sv
// External I/O responder: scratch, GPIO, TX FIFO and cycle counter registers
// behind a req/ack handshake with a configurable number of wait states.
module ext_io_responder
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
#(
    parameter logic [PC_SZ-1:0] BASE_ADDR   = Ext_IO_Addr_Lo,
    parameter int               WAIT_STATES = 1,
    parameter int               FIFO_DEPTH  = 4
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             io_req,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [PC_SZ-1:0] io_addr,
    input  logic [RSZ-1:0]   io_wr_data,
    output logic [RSZ-1:0]   io_rd_data,
    output logic             io_ack,
    output logic             io_ack_fault,
    output logic [RSZ-1:0]   gpio_out,
    input  logic [RSZ-1:0]   gpio_in,
    output logic             tx_valid,
    output logic [RSZ-1:0]   tx_data,
    input  logic             tx_ready
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    io_state_t        state;
    io_state_t        next_state;
    io_access_t       held;
    io_access_t       cur;
    logic [3:0]       wait_cnt;
    logic [RSZ-1:0]   scratch0;
    logic [RSZ-1:0]   scratch1;
    logic [RSZ-1:0]   gpio_meta;
    logic [RSZ-1:0]   gpio_sync;
    logic [RSZ-1:0]   cycle_cnt;
    logic [RSZ-1:0]   tx_stat;
    logic [RSZ-1:0]   rd_value;
    logic [PC_SZ-1:0] offset;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             commit;
    logic             fault;
    logic             wr_ok;
    logic             push;
    logic             pop;

    // With zero wait states the commit edge is the capture edge, so decode
    // must look at the live bus while idle and at the held copy afterwards.
    assign cur = (state == IDLE) ?
                 io_access_t'{rd: io_rd, wr: io_wr, addr: io_addr, data: io_wr_data} : held;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state    <= IDLE;
            wait_cnt <= '0;
            held     <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && io_req) begin
                held     <= cur;
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (io_req) next_state = (WAIT_STATES > 0) ? WAIT : ACK;
            WAIT:    if (wait_cnt == 4'd0) next_state = ACK;
            ACK:     next_state = RECOVER;
            RECOVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign commit = (next_state == ACK);
    assign offset = cur.addr - BASE_ADDR;
    assign pop    = tx_valid && tx_ready;
    assign wr_ok  = commit && cur.wr && !fault;
    assign push   = wr_ok && (offset == OFF_TX_DATA);

    always_comb begin
        tx_stat = '0;
        tx_stat[TX_STAT_COUNT_MSB:TX_STAT_COUNT_LSB] = 4'(fifo_count);
        tx_stat[TX_STAT_FULL_BIT]  = fifo_full;
        tx_stat[TX_STAT_EMPTY_BIT] = fifo_empty;
    end

    // Addresses below the base wrap to huge offsets and fall out as unmapped.
    always_comb begin
        fault    = 1'b0;
        rd_value = '0;
        if (cur.rd == cur.wr || offset[1:0] != 2'b00 || offset > OFF_CYCLE_CNT) begin
            fault = 1'b1;
        end else begin
            case (offset)
                OFF_SCRATCH0:  rd_value = scratch0;
                OFF_SCRATCH1:  rd_value = scratch1;
                OFF_GPIO_OUT:  rd_value = gpio_out;
                OFF_GPIO_IN: begin
                    rd_value = gpio_sync;
                    fault    = cur.wr;
                end
                OFF_TX_DATA:   fault = cur.rd || (fifo_full && !pop);
                OFF_TX_STAT: begin
                    rd_value = tx_stat;
                    fault    = cur.wr;
                end
                OFF_CYCLE_CNT: begin
                    rd_value = cycle_cnt;
                    fault    = cur.wr;
                end
                default:       fault = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            io_ack       <= 1'b0;
            io_ack_fault <= 1'b0;
            io_rd_data   <= '0;
        end else begin
            io_ack       <= commit;
            io_ack_fault <= commit && fault;
            io_rd_data   <= (commit && cur.rd && !fault) ? rd_value : '0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            scratch0 <= '0;
            scratch1 <= '0;
            gpio_out <= '0;
        end else if (wr_ok) begin
            if (offset == OFF_SCRATCH0) scratch0 <= cur.data;
            if (offset == OFF_SCRATCH1) scratch1 <= cur.data;
            if (offset == OFF_GPIO_OUT) gpio_out <= cur.data;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            gpio_meta <= '0;
            gpio_sync <= '0;
            cycle_cnt <= '0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RSZ)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .push      (push),
        .push_data (cur.data),
        .pop       (pop),
        .pop_data  (tx_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign tx_valid = !fifo_empty;

endmodule

// File: tb/tb_ext_io_responder.sv
// Directed bench for ext_io_responder: expected responses are queued when an
// access is issued and compared when io_ack is observed (sampled on negedges).
module tb_ext_io_responder;

    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;

    localparam int               WS     = 1;
    localparam int               DEPTH  = 4;
    localparam int               BUDGET = 20;
    localparam logic [PC_SZ-1:0] BASE   = Ext_IO_Addr_Lo;

    logic             clk_in;
    logic             reset_in;
    logic             io_req;
    logic             io_rd;
    logic             io_wr;
    logic [PC_SZ-1:0] io_addr;
    logic [RSZ-1:0]   io_wr_data;
    logic [RSZ-1:0]   io_rd_data;
    logic             io_ack;
    logic             io_ack_fault;
    logic [RSZ-1:0]   gpio_out;
    logic [RSZ-1:0]   gpio_in;
    logic             tx_valid;
    logic [RSZ-1:0]   tx_data;
    logic             tx_ready;

    typedef struct {
        logic [RSZ-1:0] data;
        logic           fault;
    } exp_t;

    exp_t           sb[$];
    logic [RSZ-1:0] tx_exp[$];
    int             assert_cnt = 0;
    int             fail_cnt   = 0;
    logic [RSZ-1:0] tb_cycles;

    ext_io_responder #(
        .BASE_ADDR   (BASE),
        .WAIT_STATES (WS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .io_req       (io_req),
        .io_rd        (io_rd),
        .io_wr        (io_wr),
        .io_addr      (io_addr),
        .io_wr_data   (io_wr_data),
        .io_rd_data   (io_rd_data),
        .io_ack       (io_ack),
        .io_ack_fault (io_ack_fault),
        .gpio_out     (gpio_out),
        .gpio_in      (gpio_in),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference free-running counter, cleared by the same reset as the DUT.
    always @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) tb_cycles <= '0;
        else           tb_cycles <= tb_cycles + 1'b1;
    end

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            checkValue({tag, " scoreboard"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        checkValue({tag, " latency"}, 32'(lat), 32'(1 + WS));
        checkValue({tag, " rd_data"}, io_rd_data, e.data);
        checkValue({tag, " fault"}, 32'(io_ack_fault), 32'(e.fault));
        @(negedge clk_in);
        checkValue({tag, " ack_one_cycle"}, 32'(io_ack), 32'd0);
        checkValue({tag, " rd_data_cleared"}, io_rd_data, 32'd0);
    endtask

    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [PC_SZ-1:0] off, input logic [RSZ-1:0] wdata,
                                 input logic [RSZ-1:0] exp_data, input logic exp_fault,
                                 input logic exp_cycle, input logic pulse_ready);
        exp_t e;
        bit   seen;
        int   lat;
        @(negedge clk_in);
        io_req     = 1'b1;
        io_rd      = rd;
        io_wr      = wr;
        io_addr    = BASE + off;
        io_wr_data = wdata;
        @(posedge clk_in);
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < BUDGET && !seen; k++) begin
            @(negedge clk_in);
            if (k == 0) begin
                io_req  = 1'b0;
                e.data  = exp_cycle ? tb_cycles + RSZ'(WS) - 1'b1 : exp_data;
                e.fault = exp_fault;
                sb.push_back(e);
                if (pulse_ready && tx_exp.size() > 0) begin
                    checkValue({tag, " popped_word"}, tx_data, tx_exp.pop_front());
                end
            end
            if (pulse_ready) tx_ready = (k == WS - 1);
            if (io_ack) begin
                seen = 1'b1;
                lat  = k + 1;
            end else begin
                checkValue({tag, " rd_data_idle"}, io_rd_data, 32'd0);
            end
        end
        if (!seen) begin
            checkValue({tag, " ack_timeout"}, 32'(seen), 32'd1);
            void'(sb.pop_front());
        end else begin
            checkOutput(tag, lat);
        end
    endtask

    task automatic drainFifo(input string tag);
        int n;
        n = tx_exp.size();
        @(negedge clk_in);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            checkValue($sformatf("%s valid%0d", tag, i), 32'(tx_valid), 32'd1);
            checkValue($sformatf("%s word%0d", tag, i), tx_data, tx_exp.pop_front());
            @(negedge clk_in);
        end
        tx_ready = 1'b0;
        checkValue({tag, " empty"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        logic [RSZ-1:0] w;
        int             ack_seen;

        reset_in   = 1'b0;
        io_req     = 1'b0;
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        io_addr    = '0;
        io_wr_data = '0;
        gpio_in    = '0;
        tx_ready   = 1'b0;

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checkValue("reset io_ack", 32'(io_ack), 32'd0);
        checkValue("reset io_ack_fault", 32'(io_ack_fault), 32'd0);
        checkValue("reset io_rd_data", io_rd_data, 32'd0);
        checkValue("reset tx_valid", 32'(tx_valid), 32'd0);
        checkValue("reset tx_data", tx_data, 32'd0);
        checkValue("reset gpio_out", gpio_out, 32'd0);
        reset_in = 1'b1;
        $display("[TB] reset released");

        applyStimulus("wr_scratch0", 0, 1, OFF_SCRATCH0, 32'hDEAD_BEEF, 32'd0, 0, 0, 0);
        applyStimulus("rd_scratch0", 1, 0, OFF_SCRATCH0, 32'd0, 32'hDEAD_BEEF, 0, 0, 0);
        applyStimulus("wr_scratch1", 0, 1, OFF_SCRATCH1, 32'h0BAD_F00D, 32'd0, 0, 0, 0);
        applyStimulus("wr_gpio_out", 0, 1, OFF_GPIO_OUT, 32'h1234_5678, 32'd0, 0, 0, 0);
        checkValue("gpio_out pins", gpio_out, 32'h1234_5678);
        applyStimulus("rd_gpio_out", 1, 0, OFF_GPIO_OUT, 32'd0, 32'h1234_5678, 0, 0, 0);

        $display("[TB] faulting accesses");
        applyStimulus("rd_unmapped_1c", 1, 0, 32'h1C, 32'd0, 32'd0, 1, 0, 0);
        applyStimulus("wr_misaligned_02", 0, 1, 32'h02, 32'hFFFF_FFFF, 32'd0, 1, 0, 0);
        applyStimulus("rd_below_base", 1, 0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1, 0, 0);
        applyStimulus("rd_and_wr", 1, 1, OFF_SCRATCH0, 32'h0000_0001, 32'd0, 1, 0, 0);
        applyStimulus("neither_rd_wr", 0, 0, OFF_SCRATCH1, 32'h0000_0002, 32'd0, 1, 0, 0);
        applyStimulus("wr_gpio_in_ro", 0, 1, OFF_GPIO_IN, 32'h0000_0003, 32'd0, 1, 0, 0);
        applyStimulus("rd_tx_data_wo", 1, 0, OFF_TX_DATA, 32'd0, 32'd0, 1, 0, 0);
        applyStimulus("wr_tx_stat_ro", 0, 1, OFF_TX_STAT, 32'h0000_0004, 32'd0, 1, 0, 0);
        applyStimulus("wr_cycle_ro", 0, 1, OFF_CYCLE_CNT, 32'h0000_0005, 32'd0, 1, 0, 0);
        applyStimulus("rd_scratch0_kept", 1, 0, OFF_SCRATCH0, 32'd0, 32'hDEAD_BEEF, 0, 0, 0);
        applyStimulus("rd_scratch1_kept", 1, 0, OFF_SCRATCH1, 32'd0, 32'h0BAD_F00D, 0, 0, 0);
        checkValue("gpio_out kept", gpio_out, 32'h1234_5678);
        checkValue("no push from faults", 32'(tx_valid), 32'd0);

        $display("[TB] fifo overflow with tx_ready low");
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'hA000_0000 + RSZ'(i);
            tx_exp.push_back(w);
            applyStimulus($sformatf("push%0d", i), 0, 1, OFF_TX_DATA, w, 32'd0, 0, 0, 0);
        end
        applyStimulus("tx_stat_full", 1, 0, OFF_TX_STAT, 32'd0, 32'h0000_0012, 0, 0, 0);
        applyStimulus("push_overflow", 0, 1, OFF_TX_DATA, 32'hBAD0_0005, 32'd0, 1, 0, 0);
        applyStimulus("tx_stat_after_overflow", 1, 0, OFF_TX_STAT, 32'd0, 32'h0000_0012, 0, 0, 0);
        drainFifo("drain1");
        applyStimulus("tx_stat_empty", 1, 0, OFF_TX_STAT, 32'd0, 32'h0000_0001, 0, 0, 0);

        $display("[TB] push into full fifo with simultaneous pop");
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'hB000_0000 + RSZ'(i);
            tx_exp.push_back(w);
            applyStimulus($sformatf("refill%0d", i), 0, 1, OFF_TX_DATA, w, 32'd0, 0, 0, 0);
        end
        tx_exp.push_back(32'hB000_0004);
        applyStimulus("push_full_with_pop", 0, 1, OFF_TX_DATA, 32'hB000_0004, 32'd0, 0, 0, 1);
        applyStimulus("tx_stat_still_full", 1, 0, OFF_TX_STAT, 32'd0, 32'h0000_0012, 0, 0, 0);
        drainFifo("drain2");

        applyStimulus("rd_cycle_a", 1, 0, OFF_CYCLE_CNT, 32'd0, 32'd0, 0, 1, 0);
        applyStimulus("rd_cycle_b", 1, 0, OFF_CYCLE_CNT, 32'd0, 32'd0, 0, 1, 0);

        $display("[TB] gpio_in synchronizer");
        @(posedge clk_in);
        #1 gpio_in = 32'h0000_00A5;
        applyStimulus("gpio_in_early", 1, 0, OFF_GPIO_IN, 32'd0, 32'd0, 0, 0, 0);
        applyStimulus("gpio_in_synced", 1, 0, OFF_GPIO_IN, 32'd0, 32'h0000_00A5, 0, 0, 0);

        $display("[TB] reset during wait");
        @(negedge clk_in);
        io_req     = 1'b1;
        io_rd      = 1'b0;
        io_wr      = 1'b1;
        io_addr    = BASE + OFF_SCRATCH0;
        io_wr_data = 32'h0000_0055;
        @(posedge clk_in);
        @(negedge clk_in);
        io_req = 1'b0;
        checkValue("abort state_wait", 32'(dut.state), 32'(WAIT));
        reset_in = 1'b0;
        ack_seen = 0;
        #1;
        checkValue("abort state_idle_in_reset", 32'(dut.state), 32'(IDLE));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            if (i == 2) reset_in = 1'b1;
            if (io_ack) ack_seen++;
        end
        checkValue("abort no_ack", 32'(ack_seen), 32'd0);
        checkValue("abort state_idle", 32'(dut.state), 32'(IDLE));
        applyStimulus("abort scratch0", 1, 0, OFF_SCRATCH0, 32'd0, 32'd0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
